// File: rtl/timer_ctrl_16_pkg.sv
// Shared types and defaults for the 16-bit interval timer controller.
package timer_ctrl_16_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/timer_ctrl_16_if.sv
// Control/status bundle between firmware-facing logic and the timer.
interface timer_ctrl_16_if
  import timer_ctrl_16_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
);
  logic                  start;
  logic                  stop;
  logic                  hold;
  logic                  periodic;
  logic [WIDTH-1:0]      period;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tick;
  logic                  err;

  modport master (
    output start, stop, hold, periodic, period, prescale,
    input  count, busy, tick, err
  );

  modport slave (
    input  start, stop, hold, periodic, period, prescale,
    output count, busy, tick, err
  );
endinterface

// File: rtl/timer_ctrl_16_counter.sv
// Enable-gated up-counter with a synchronous clear that wins over enable.
module counter_up_sync_clr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clear)       q_d = '0;
    else if (enable) q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) q_q <= '0;
    else          q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/timer_ctrl_16.sv
// Interval timer: IDLE/RUN/HOLD sequencer, inline prescaler and terminal-count tick.
module timer_ctrl_16
  import timer_ctrl_16_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic              clk,
  input  logic              n_reset,
  timer_ctrl_16_if.slave    bus
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      per_q, per_d;
  logic                  mode_q, mode_d;
  logic                  busy_q, busy_d;
  logic                  tick_q, tick_d;
  logic                  err_q, err_d;

  logic                  cnt_en, cnt_clr;
  logic [WIDTH-1:0]      cnt;
  logic                  strobe;
  logic [WIDTH-1:0]      last_cnt;

  assign strobe   = (presc_q == psc_q);
  assign last_cnt = per_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    psc_d   = psc_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    err_d   = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.period != '0) begin
            per_d   = bus.period;
            psc_d   = bus.prescale;
            mode_d  = bus.periodic;
            presc_d = '0;
            cnt_clr = 1'b1;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // stop beats a coincident terminal strobe, so no tick escapes an abort
        if (bus.stop) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (bus.hold) begin
          state_d = HOLD;
        end else if (strobe) begin
          presc_d = '0;
          cnt_en  = 1'b1;
          if (cnt == last_cnt) begin
            cnt_clr = 1'b1;
            tick_d  = 1'b1;
            if (!mode_q) state_d = IDLE;
          end
        end else begin
          presc_d = presc_q + PRESCALE_W'(1);
        end
      end
      HOLD: begin
        if (bus.stop) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (!bus.hold) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      psc_q   <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      psc_q   <= psc_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  counter_up_sync_clr #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .n_reset (n_reset),
    .enable  (cnt_en),
    .clear   (cnt_clr),
    .Q       (cnt)
  );

  assign bus.count = cnt;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_timer_ctrl_16.sv
// Directed bench for timer_ctrl_16; expected outputs queued per edge and drained after it.
module tb_timer_ctrl_16;

  logic clk;
  logic n_reset;

  timer_ctrl_16_if #(.WIDTH(16), .PRESCALE_W(8)) bus ();

  timer_ctrl_16 #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        busy;
    logic        tick;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscmp  = 0;

  task automatic push(input string tag, input logic [15:0] c, input logic b, input logic t, input logic e);
    exp_t x;
    x.tag = tag; x.cnt = c; x.busy = b; x.tick = t; x.err = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      vectors++;
      assert ({bus.count, bus.busy, bus.tick, bus.err} === {x.cnt, x.busy, x.tick, x.err})
      else begin
        miscmp++;
        $error("FAIL %s: got cnt=%0d busy=%b tick=%b err=%b, exp cnt=%0d busy=%b tick=%b err=%b",
               x.tag, bus.count, bus.busy, bus.tick, bus.err, x.cnt, x.busy, x.tick, x.err);
      end
    end
  endtask

  // queue the expectation for after the next edge, take the edge, check
  task automatic cyc(input string tag, input logic [15:0] c, input logic b, input logic t, input logic e);
    push(tag, c, b, t, e);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic arm(input logic [15:0] p, input logic [7:0] s, input logic per);
    bus.start = 1'b1; bus.period = p; bus.prescale = s; bus.periodic = per;
  endtask

  initial begin
    n_reset = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.periodic = 1'b0;
    bus.period = '0; bus.prescale = '0;
    #2;
    push("reset", 16'd0, 1'b0, 1'b0, 1'b0); drain();
    #10 n_reset = 1'b1;
    cyc("idle0", 0, 0, 0, 0);

    // one-shot P=3 S=0
    arm(16'd3, 8'd0, 1'b0);
    cyc("os_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    cyc("os_e1", 1, 1, 0, 0);
    cyc("os_e2", 2, 1, 0, 0);
    cyc("os_tick", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("os_after", 0, 0, 0, 0);

    // periodic P=4 S=1: count steps every 2 edges, tick every 8
    arm(16'd4, 8'd1, 1'b1);
    cyc("per_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 24; k++)
      cyc($sformatf("per_e%0d", k), 16'((k / 2) % 4), 1'b1, (k % 8) == 0, 1'b0);
    bus.stop = 1'b1;
    cyc("per_stop", 0, 0, 0, 0);
    bus.stop = 1'b0;

    // stop coincident with terminal strobe P=2 S=0
    arm(16'd2, 8'd0, 1'b0);
    cyc("st_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    cyc("st_e1", 1, 1, 0, 0);
    bus.stop = 1'b1;
    cyc("st_e2_stop", 0, 0, 0, 0);
    bus.stop = 1'b0;
    cyc("st_after", 0, 0, 0, 0);

    // hold for 5 edges mid-run P=10 S=0: tick moves from edge 10 to 16
    arm(16'd10, 8'd0, 1'b0);
    cyc("hd_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    for (int e = 1; e <= 3; e++) cyc($sformatf("hd_e%0d", e), 16'(e), 1, 0, 0);
    bus.hold = 1'b1;
    for (int e = 4; e <= 8; e++) cyc($sformatf("hd_frozen%0d", e), 3, 1, 0, 0);
    bus.hold = 1'b0;
    cyc("hd_resume", 3, 1, 0, 0);
    for (int e = 10; e <= 15; e++) cyc($sformatf("hd_e%0d", e), 16'(e - 6), 1, 0, 0);
    cyc("hd_tick16", 0, 0, 1, 0);

    // period==0 rejected
    arm(16'd0, 8'd0, 1'b0);
    cyc("err_pulse", 0, 0, 0, 1);
    bus.start = 1'b0;
    cyc("err_clear", 0, 0, 0, 0);

    // start while running is ignored, including a would-be err
    arm(16'd3, 8'd0, 1'b0);
    cyc("ign_start", 0, 1, 0, 0);
    bus.period = 16'd1;
    cyc("ign_e1", 1, 1, 0, 0);
    bus.period = 16'd0;
    cyc("ign_e2", 2, 1, 0, 0);
    bus.start = 1'b0;
    cyc("ign_tick", 0, 0, 1, 0);

    // asynchronous reset between edges
    arm(16'd5, 8'd0, 1'b1);
    cyc("ar_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    cyc("ar_e1", 1, 1, 0, 0);
    cyc("ar_e2", 2, 1, 0, 0);
    #2 n_reset = 1'b0;
    #1;
    push("ar_async", 0, 0, 0, 0); drain();
    cyc("ar_held", 0, 0, 0, 0);
    n_reset = 1'b1;
    cyc("ar_idle1", 0, 0, 0, 0);
    cyc("ar_idle2", 0, 0, 0, 0);

    // P=1 one-shot: tick on first strobe
    arm(16'd1, 8'd0, 1'b0);
    cyc("p1_start", 0, 1, 0, 0);
    bus.start = 1'b0;
    cyc("p1_tick", 0, 0, 1, 0);
    cyc("p1_after", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
